// File: rtl/regfile_bist_fsm.sv
// Register-file self-test sequencer: seeds and fills a register file with an
// arithmetic pattern, then reads it back against a separate expected-value pair.
module regfile_bist_fsm #(
  parameter int               WIDTH    = 16,
  parameter int               NUM_REGS = 16,
  parameter logic [WIDTH-1:0] SEED_A   = '0,
  parameter logic [WIDTH-1:0] SEED_B   = WIDTH'(1),
  localparam int              IW       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             inject_fault,
  output logic [WIDTH-1:0] rout,
  output logic [3:0]       state,
  output logic             done,
  output logic             pass,
  output logic [IW-1:0]    fail_idx
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_SEED0  = 4'd1,
    S_SEED1  = 4'd2,
    S_FILL   = 4'd3,
    S_VERIFY = 4'd4,
    S_DONE   = 4'd5
  } state_t;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REGS - 1);
  localparam logic [IW-1:0] FAULT_IDX = IW'(NUM_REGS / 2);

  state_t           st;
  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [IW-1:0]    idx;
  logic [1:0]       mode_q;
  logic             fault_q;
  logic             fail_q;
  logic [WIDTH-1:0] exp_cur;
  logic [WIDTH-1:0] exp_nxt;

  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic [WIDTH-1:0] fill_val;
  logic [WIDTH-1:0] rd_val;

  function automatic logic [WIDTH-1:0] step(input logic [1:0]       m,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    unique case (m)
      2'b00:   return a + b;
      2'b01:   return a + WIDTH'(1);
      2'b10:   return a - b;
      default: return a ^ b;
    endcase
  endfunction

  // Fill operands come straight out of the array: a write at edge n is visible at n+1.
  assign a_val    = regs[idx - IW'(1)];
  assign b_val    = regs[idx - IW'(2)];
  assign fill_val = step(mode_q, a_val, b_val)
                  ^ ((fault_q && idx == FAULT_IDX) ? WIDTH'(1) : '0);
  assign rd_val   = regs[idx];
  assign state    = st;

  // NOTE: every state element, including the register file, updates with <=
  // so all reads in this block see the pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= S_IDLE;
      idx      <= '0;
      mode_q   <= '0;
      fault_q  <= 1'b0;
      fail_q   <= 1'b0;
      exp_cur  <= '0;
      exp_nxt  <= '0;
      rout     <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_idx <= '0;
      // NOTE: the register file is built from flops and must read as zero after
      // reset, so it is cleared here like any other state rather than left as a RAM.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      unique case (st)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_q   <= mode;
            fault_q  <= inject_fault;
            fail_q   <= 1'b0;
            fail_idx <= '0;
            pass     <= 1'b0;
            done     <= 1'b0;
            st       <= S_SEED0;
          end else if (st == S_DONE) begin
            done <= 1'b1;
            pass <= !fail_q;
          end
        end
        S_SEED0: begin
          regs[0] <= SEED_A;
          rout    <= SEED_A;
          st      <= S_SEED1;
        end
        S_SEED1: begin
          regs[1] <= SEED_B;
          rout    <= SEED_B;
          idx     <= IW'(2);
          st      <= S_FILL;
        end
        S_FILL: begin
          regs[idx] <= fill_val;
          rout      <= fill_val;
          if (idx == LAST_IDX) begin
            idx     <= '0;
            exp_cur <= SEED_A;
            exp_nxt <= SEED_B;
            st      <= S_VERIFY;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_VERIFY: begin
          rout <= rd_val;
          if (rd_val != exp_cur && !fail_q) begin
            fail_q   <= 1'b1;
            fail_idx <= idx;
          end
          // Expected pair slides one step, independent of what the array holds.
          exp_cur <= exp_nxt;
          exp_nxt <= step(mode_q, exp_nxt, exp_cur);
          if (idx == LAST_IDX) st <= S_DONE;
          else                 idx <= idx + IW'(1);
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bist_fsm.sv
// Bench for regfile_bist_fsm: a 16-bit and an 8-bit instance run side by side
// against a timeline model, plus hand-computed checkpoints.
module tb_regfile_bist_fsm;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic        inject_fault;

  logic [15:0] rout16;
  logic [3:0]  state16;
  logic        done16, pass16;
  logic [3:0]  fidx16;
  logic [7:0]  rout8;
  logic [3:0]  state8;
  logic        done8, pass8;
  logic [3:0]  fidx8;

  regfile_bist_fsm dut16 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .inject_fault(inject_fault),
    .rout(rout16), .state(state16), .done(done16), .pass(pass16), .fail_idx(fidx16)
  );

  regfile_bist_fsm #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .inject_fault(inject_fault),
    .rout(rout8), .state(state8), .done(done8), .pass(pass8), .fail_idx(fidx8)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: index 0 is the 16-bit instance, index 1 the 8-bit instance.
  logic [15:0] msk [2] = '{16'hFFFF, 16'h00FF};
  logic [15:0] mv  [2][N];   // values actually stored (fault applied)
  logic [15:0] mx  [2][N];   // fault-free expected sequence
  int          m_state;
  int          s;
  bit          m_done;
  logic [15:0] m_rout   [2];
  bit          m_pass   [2];
  int          m_fidx   [2];
  bit          m_failed [2];
  bit          cmp_en = 1'b0;

  function automatic logic [15:0] pat(input logic [1:0] m, input logic [15:0] a,
                                      input logic [15:0] b, input logic [15:0] k);
    case (m)
      2'd0:    return (a + b) & k;
      2'd1:    return (a + 16'd1) & k;
      2'd2:    return (a - b) & k;
      default: return (a ^ b) & k;
    endcase
  endfunction

  task automatic build(input logic [1:0] m, input bit f);
    for (int w = 0; w < 2; w++) begin
      mv[w][0] = 16'd0; mv[w][1] = 16'd1;
      mx[w][0] = 16'd0; mx[w][1] = 16'd1;
      for (int k = 2; k < N; k++) begin
        mx[w][k] = pat(m, mx[w][k-1], mx[w][k-2], msk[w]);
        mv[w][k] = pat(m, mv[w][k-1], mv[w][k-2], msk[w]);
        if (f && k == N / 2) mv[w][k] = mv[w][k] ^ 16'h1;
      end
    end
  endtask

  // Timeline model: s counts edges since the accepting edge.
  always @(posedge clk) begin
    if (reset) begin
      m_state = 0; s = 0; m_done = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_rout[w] = '0; m_pass[w] = 1'b0; m_fidx[w] = 0; m_failed[w] = 1'b0;
      end
    end else if ((m_state == 0 || m_state == 5) && start) begin
      build(mode, inject_fault);
      s = 0; m_state = 1; m_done = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_pass[w] = 1'b0; m_fidx[w] = 0; m_failed[w] = 1'b0;
      end
    end else if (m_state == 5) begin
      m_done = 1'b1;
      for (int w = 0; w < 2; w++) m_pass[w] = !m_failed[w];
    end else if (m_state != 0) begin
      s++;
      for (int w = 0; w < 2; w++) begin
        if (s <= N) begin
          m_rout[w] = mv[w][s-1];
        end else begin
          m_rout[w] = mv[w][s-N-1];
          if (mv[w][s-N-1] != mx[w][s-N-1] && !m_failed[w]) begin
            m_failed[w] = 1'b1;
            m_fidx[w]   = s - N - 1;
          end
        end
      end
      m_state = (s == 1) ? 2 : (s < N) ? 3 : (s < 2 * N) ? 4 : 5;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("state16", 32'(state16), 32'(m_state));
      check("state8",  32'(state8),  32'(m_state));
      check("rout16",  32'(rout16),  32'(m_rout[0]));
      check("rout8",   32'(rout8),   32'(m_rout[1]));
      check("done16",  32'(done16),  32'(m_done));
      check("done8",   32'(done8),   32'(m_done));
      check("pass16",  32'(pass16),  32'(m_pass[0]));
      check("pass8",   32'(pass8),   32'(m_pass[1]));
      check("fidx16",  32'(fidx16),  32'(m_fidx[0]));
      check("fidx8",   32'(fidx8),   32'(m_fidx[1]));
    end
  end

  int pos;

  task automatic run_start(input logic [1:0] m, input bit f);
    @(negedge clk);
    mode = m; inject_fault = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pos = 0;
  endtask

  task automatic to_edge(input int n);
    repeat (n - pos) @(negedge clk);
    pos = n;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; inject_fault = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_state", 32'(state16), 32'd0);
    check("reset_rout",  32'(rout16),  32'd0);
    check("reset_done",  32'(done16),  32'd0);
    check("reset_pass",  32'(pass16),  32'd0);
    check("reset_fidx",  32'(fidx16),  32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Fibonacci, both widths.
    run_start(2'd0, 1'b0);
    to_edge(15); check("fib8_r14", 32'(rout8), 32'd121);
    to_edge(16); check("fib16_r15", 32'(rout16), 32'h0262);
                 check("fib8_r15",  32'(rout8),  32'd98);
    to_edge(32); check("fib_done_e32", 32'(done16), 32'd0);
                 check("fib_state_e32", 32'(state16), 32'd5);
    to_edge(33); check("fib_done_e33", 32'(done16), 32'd1);
                 check("fib_pass16", 32'(pass16), 32'd1);
                 check("fib_pass8",  32'(pass8),  32'd1);
    repeat (3) @(negedge clk);

    // Subtract, then xor via restart straight from DONE.
    run_start(2'd2, 1'b0);
    to_edge(5);  check("sub_r4",  32'(rout16), 32'hFFFF);
    to_edge(16); check("sub_r15", 32'(rout16), 32'd0);
    to_edge(33); check("sub_pass", 32'(pass16), 32'd1);
    run_start(2'd3, 1'b0);
    check("restart_done_low", 32'(done16), 32'd0);
    to_edge(16); check("xor_r15", 32'(rout16), 32'd0);
    to_edge(33); check("xor_pass", 32'(pass16), 32'd1);
    repeat (2) @(negedge clk);

    // Increment with a planted fault at r[8].
    run_start(2'd1, 1'b1);
    to_edge(9);  check("flt_r8_16", 32'(rout16), 32'd9);
                 check("flt_r8_8",  32'(rout8),  32'd9);
    to_edge(16); check("flt_r15", 32'(rout16), 32'd16);
    to_edge(25); check("flt_fidx_e25", 32'(fidx16), 32'd8);
    to_edge(30); check("flt_fidx_e30", 32'(fidx16), 32'd8);
    to_edge(33); check("flt_done", 32'(done16), 32'd1);
                 check("flt_pass", 32'(pass16), 32'd0);
                 check("flt_fidx", 32'(fidx16), 32'd8);
    repeat (2) @(negedge clk);

    // Reset during FILL with idx=7, then a clean run with start pulsed in VERIFY.
    run_start(2'd0, 1'b0);
    to_edge(7);  reset = 1'b1;
    to_edge(8);  check("mid_rst_state", 32'(state16), 32'd0);
                 check("mid_rst_rout",  32'(rout16),  32'd0);
                 check("mid_rst_done",  32'(done16),  32'd0);
    reset = 1'b0;
    run_start(2'd0, 1'b0);
    to_edge(20); start = 1'b1;
    to_edge(21); start = 1'b0;
                 check("vstart_state", 32'(state16), 32'd4);
    to_edge(32); check("vstart_done_e32", 32'(done16), 32'd0);
    to_edge(33); check("vstart_done", 32'(done16), 32'd1);
                 check("vstart_pass", 32'(pass16), 32'd1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_bist_fsm.md
# regfile_bist_fsm

Parametrised self-checking sequencer that exercises an internal register file with a selectable arithmetic fill pattern, then reads every register back against an independently generated expected value. It succeeds the fixed 16×16 register-file demo FSM. It is the board-level and bench-level confidence check for register-file and adder datapaths. Results appear on `rout`, `state`, `done` and `pass`.

## Interface
- `WIDTH`, 16: data width of each register and of `rout`.
- `NUM_REGS`, 16: register count. Legal range is 4..256. Index width is IW = clog2(NUM_REGS).
- `SEED_A`, 0: value written to r[0].
- `SEED_B`, 1: value written to r[1].
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: starts a run. Sampled only in IDLE or DONE.
- `mode` input 2: fill pattern, latched when `start` is accepted.
- `inject_fault` input 1: when latched at start, forces a deliberate corruption of one write.
- `rout` output WIDTH: the value written (fill phases) or read (verify phase) in the current step.
- `state` output 4: current state encoding.
- `done` output 1: high in DONE.
- `pass` output 1: valid only while `done` is high; 1 means no mismatch was found.
- `fail_idx` output IW: index of the first mismatching register.

## Operation
- State encoding: IDLE=0, SEED0=1, SEED1=2, FILL=3, VERIFY=4, DONE=5. Codes 6–15 are unreachable; if entered, the next edge goes to IDLE.
- IDLE:
  - `start`=1 latches `mode` and `inject_fault`, then moves to SEED0.
  - Leaving IDLE clears `fail_idx`, the sticky fail flag and `pass`.
- SEED0: writes r[0]=SEED_A, sets `rout`=SEED_A, moves to SEED1.
- SEED1: writes r[1]=SEED_B, sets `rout`=SEED_B, sets idx=2, moves to FILL.
- FILL: each cycle writes r[idx]=f(r[idx-1], r[idx-2]), sets `rout` to the written value, and increments idx. The pattern f depends on `mode`; all arithmetic wraps modulo 2^WIDTH:
  - 00: a+b (Fibonacci).
  - 01: a+1 (increment).
  - 10: a−b (subtract).
  - 11: a^b (xor).
  - Here a = r[idx-1] and b = r[idx-2].
- Fault injection: when latched `inject_fault`=1, the write to r[NUM_REGS/2] has bit 0 inverted. `rout` shows the corrupted value. Later FILL steps use the corrupted stored value.
- Leaving FILL: after writing r[NUM_REGS-1], go to VERIFY with idx=0.
- Expected-value generator: a separate register pair, not the register file. It is reseeded from SEED_A and SEED_B and steps with the same f.
- VERIFY: each cycle sets `rout`=r[idx] and compares it with the expected value.
  - On the first mismatch: set the sticky fail flag and capture `fail_idx`=idx.
  - Later mismatches do not change `fail_idx`.
  - After idx=NUM_REGS-1, go to DONE.
- DONE: `done`=1 and `pass`=!fail. The block holds until `start`=1, which restarts at SEED0 with the newly latched mode.
- `start` is ignored in SEED0, SEED1, FILL and VERIFY.

## Timing
- Reset values (every output): `state`=IDLE (0), `rout`=0, `done`=0, `pass`=0, `fail_idx`=0. Reset also clears all registers to 0, idx to 0 and the sticky fail flag.
- Reset mid-run: the next edge is fully in reset state and the run is abandoned. No partial result is visible.
- Outputs are registered; `rout` and `state` update on the same edge as the write or compare.
- With `start` sampled at edge 0:
  - r[0] is written at edge 1 and r[1] at edge 2.
  - r[k] is written at edge k+1, so FILL ends at edge NUM_REGS.
  - VERIFY compares idx k at edge NUM_REGS+1+k.
  - `done` rises after edge 2·NUM_REGS+1, which is 33 for the defaults.
- `done` falls on the edge that accepts a restart `start`.
- Register-file reads are combinational from the array: write at edge n, readable at edge n+1.

## Test plan
- Fibonacci, defaults, mode=00: FILL `rout` sequence is 0,1,1,2,3,5,…,610 (0x0262) at edge 16. `done`=1 after edge 33, `pass`=1.
- WIDTH=8, mode=00: r[14]=121 and r[15]=98 (wrap-around). `pass`=1.
- mode=10, defaults: values are 0,1,1,0,0xFFFF,0xFFFF,0,1,… with r[15]=0. `pass`=1. Then mode=11 via restart from DONE: r[15]=0 and `pass`=1, with no reset in between.
- `inject_fault`=1, mode=01: r[8]=9 (bit 0 flipped), r[15]=16. Result is `pass`=0, `fail_idx`=8, and `fail_idx` stays 8 despite later mismatches.
- Reset asserted during FILL at idx=7: next cycle `state`=0, `rout`=0 and registers are cleared. A following run completes with `pass`=1.
- `start` pulsed during VERIFY: ignored, with no change in `state` sequence or timing.
